// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transmit-only slave.
package spi_pkg;

    localparam int unsigned SPI_FRAME_W = 8;
    localparam int unsigned SPI_IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous input, plus a history flop for edge detection.
module spi_sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
            hist_q <= ResetVal;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~hist_q;
    assign fall  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_slave_tx.sv
// SPI mode 0 transmit-only slave: latches a byte at frame start and shifts it out LSB first
// on sck falling edges, with sck/ss oversampled on the system clock.
module spi_slave_tx
    import spi_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [SPI_FRAME_W-1:0] data,
    input  logic                   ss,
    input  logic                   sck,
    output logic                   miso,
    output logic                   busy,
    output logic [1:0]             dbg_cs,
    output logic [SPI_IDX_W-1:0]   dbg_idx,
    output logic [SPI_FRAME_W-1:0] dbg_data
);

    localparam int unsigned SelW = $clog2(SPI_FRAME_W);
    localparam logic [SPI_IDX_W-1:0] FrameLen = SPI_IDX_W'(SPI_FRAME_W);

    logic sck_lvl, sck_rise, sck_fall;
    logic ss_lvl, ss_rise, ss_fall;
    logic unused_edges;

    spi_sync_edge #(
        .ResetVal (1'b0)
    ) u_sync_sck (
        .clk      (clk),
        .rst      (rst),
        .async_in (sck),
        .level    (sck_lvl),
        .rise     (sck_rise),
        .fall     (sck_fall)
    );

    // ss idles high, so its synchroniser resets to 1 to avoid a false select after reset.
    spi_sync_edge #(
        .ResetVal (1'b1)
    ) u_sync_ss (
        .clk      (clk),
        .rst      (rst),
        .async_in (ss),
        .level    (ss_lvl),
        .rise     (ss_rise),
        .fall     (ss_fall)
    );

    assign unused_edges = ^{sck_lvl, sck_rise, ss_rise, ss_fall};

    spi_state_e             state_q;
    logic [SPI_IDX_W-1:0]   idx_q;
    logic [SPI_FRAME_W-1:0] shreg_q;
    logic                   miso_q;
    logic                   busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
            miso_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sck_fall && !ss_lvl) begin
                        shreg_q <= data;
                        miso_q  <= data[0];
                        idx_q   <= SPI_IDX_W'(1);
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Deselect takes priority over a coincident sck edge.
                    if (ss_lvl) begin
                        idx_q   <= '0;
                        miso_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sck_fall) begin
                        if (idx_q < FrameLen) begin
                            miso_q <= shreg_q[idx_q[SelW-1:0]];
                            idx_q  <= idx_q + SPI_IDX_W'(1);
                        end else begin
                            miso_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (ss_lvl) begin
                        idx_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    idx_q   <= '0;
                    miso_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign miso     = miso_q;
    assign busy     = busy_q;
    assign dbg_cs   = state_q;
    assign dbg_idx  = idx_q;
    assign dbg_data = shreg_q;

endmodule

// File: tb/tb_spi_slave_tx.sv
// Directed bench for spi_slave_tx: table of frames plus hand-written corner sequences.
module tb_spi_slave_tx;

    localparam time HALF = 2500ns;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       ss;
    logic       sck;
    logic       miso;
    logic       busy;
    logic [1:0] dbg_cs;
    logic [3:0] dbg_idx;
    logic [7:0] dbg_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    spi_slave_tx dut (
        .clk      (clk),
        .rst      (rst),
        .data     (data),
        .ss       (ss),
        .sck      (sck),
        .miso     (miso),
        .busy     (busy),
        .dbg_cs   (dbg_cs),
        .dbg_idx  (dbg_idx),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #50ns clk = ~clk;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] post;
        int         nbits;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Master side: ss falls with the first sck rise, miso sampled just before each later rise.
    task automatic run_frame(input logic [7:0] tx, input logic [7:0] post, input int nbits,
                             input bit hold_ss, output logic [7:0] rx);
        @(negedge clk);
        data = tx;
        rx = '0;
        ss = 1'b0;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
        #HALF;
        data = post;
        for (int i = 0; i < nbits; i++) begin
            rx[i] = miso;
            chk("busy_in_frame", {7'd0, busy}, 8'd1);
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
            #HALF;
        end
        if (nbits < 8) begin
            chk("miso_before_abort", {7'd0, miso}, {7'd0, tx[nbits]});
            ss = 1'b1;
            repeat (3) @(posedge clk);
            #1ns;
            chk("abort_busy", {7'd0, busy}, 8'd0);
            chk("abort_miso", {7'd0, miso}, 8'd0);
            chk("abort_cs", {6'd0, dbg_cs}, 8'd0);
            #HALF;
        end else begin
            chk("end_busy", {7'd0, busy}, 8'd0);
            chk("end_miso", {7'd0, miso}, 8'd0);
            chk("end_cs", {6'd0, dbg_cs}, 8'd2);
            if (!hold_ss) begin
                ss = 1'b1;
                #HALF;
                chk("idle_cs", {6'd0, dbg_cs}, 8'd0);
            end
        end
    endtask

    initial begin
        logic [7:0] rx;

        vecs[0] = '{tx: 8'h55, post: 8'h55, nbits: 8, exp_rx: 8'h55};
        vecs[1] = '{tx: 8'hAA, post: 8'hAA, nbits: 8, exp_rx: 8'hAA};
        vecs[2] = '{tx: 8'h37, post: 8'hFF, nbits: 8, exp_rx: 8'h37};
        vecs[3] = '{tx: 8'h5A, post: 8'h5A, nbits: 3, exp_rx: 8'h02};
        vecs[4] = '{tx: 8'hC3, post: 8'hC3, nbits: 8, exp_rx: 8'hC3};
        vecs[5] = '{tx: 8'h81, post: 8'h00, nbits: 8, exp_rx: 8'h81};

        rst = 1'b1;
        ss = 1'b1;
        sck = 1'b0;
        data = 8'h00;
        repeat (4) @(posedge clk);
        #1ns;
        chk("rst_cs", {6'd0, dbg_cs}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_miso", {7'd0, miso}, 8'd0);
        chk("rst_idx", {4'd0, dbg_idx}, 8'd0);
        chk("rst_data", dbg_data, 8'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].tx, vecs[v].post, vecs[v].nbits, 1'b0, rx);
            chk("rx_byte", rx, vecs[v].exp_rx);
        end

        // ss held low after a frame: further sck pulses must not restart transmission.
        run_frame(8'h0F, 8'hFF, 8, 1'b1, rx);
        chk("hold_rx", rx, 8'h0F);
        for (int p = 0; p < 4; p++) begin
            sck = 1'b1;
            #HALF;
            sck = 1'b0;
            #HALF;
            chk("hold_busy", {7'd0, busy}, 8'd0);
            chk("hold_miso", {7'd0, miso}, 8'd0);
            chk("hold_cs", {6'd0, dbg_cs}, 8'd2);
        end
        ss = 1'b1;
        #HALF;
        run_frame(8'hF0, 8'hF0, 8, 1'b0, rx);
        chk("after_hold_rx", rx, 8'hF0);

        // Reset asserted mid-frame while miso is high.
        @(negedge clk);
        data = 8'hFF;
        ss = 1'b0;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
        #HALF;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
        #HALF;
        chk("pre_rst_miso", {7'd0, miso}, 8'd1);
        chk("pre_rst_idx", {4'd0, dbg_idx}, 8'd2);
        rst = 1'b1;
        @(posedge clk);
        #1ns;
        chk("midrst_cs", {6'd0, dbg_cs}, 8'd0);
        chk("midrst_busy", {7'd0, busy}, 8'd0);
        chk("midrst_miso", {7'd0, miso}, 8'd0);
        chk("midrst_idx", {4'd0, dbg_idx}, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        ss = 1'b1;
        repeat (10) @(posedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
